// File: rtl/rpsc_rf_sequencer.sv
// rtl/rpsc_rf_sequencer.sv - RF drive sequencer: permit/reduce interlock receiver, drive ramp, trip latch
// Optional feature: RPSC_RF_FAST_TRIP_EN gates o_rf_gate combinationally with the raw permit.
module rpsc_rf_sequencer #(
  parameter int RAMP_W      = 8,
  parameter int STEP_DIV    = 16,
  parameter int RED_LEVEL   = 'h40,
  parameter int HOLDOFF_CYC = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_not_rf_perm,
  input  logic              i_not_rf_red,
  input  logic              i_rf_on_req,
  input  logic              i_trip_ack,
  output logic [RAMP_W-1:0] o_drive_level,
  output logic              o_rf_gate,
  output logic              o_trip,
  output logic              o_ready,
  output logic [2:0]        o_state
);

  localparam int SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int HW = $clog2(HOLDOFF_CYC + 1);
  localparam logic [RAMP_W-1:0] LVL_MAX   = {RAMP_W{1'b1}};
  localparam logic [RAMP_W-1:0] LVL_RED   = RAMP_W'(RED_LEVEL);
  localparam logic [SW-1:0]     STEP_LAST = SW'(STEP_DIV - 1);
  localparam logic [HW-1:0]     HOLD_LAST = HW'(HOLDOFF_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RAMP    = 3'd1,
    S_ON      = 3'd2,
    S_REDUCED = 3'd3,
    S_TRIP    = 3'd4,
    S_HOLDOFF = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [RAMP_W-1:0] level_q, level_d, lvl_inc;
  logic              gate_q, gate_d;
  logic              trip_q, trip_d;
  logic              ready_q, ready_d;
  logic              armed_q, armed_d;
  logic [SW-1:0]     step_q, step_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [1:0]        perm_sync_q, red_sync_q;
  logic              perm_s, red_s, trip_now;

  assign perm_s = perm_sync_q[1];
  assign red_s  = red_sync_q[1];

  // Synchronisers idle high so a reset looks like "no permit, no reduce".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perm_sync_q <= 2'b11;
      red_sync_q  <= 2'b11;
    end else begin
      perm_sync_q <= {perm_sync_q[0], i_not_rf_perm};
      red_sync_q  <= {red_sync_q[0], i_not_rf_red};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      level_q <= '0;
      gate_q  <= 1'b0;
      trip_q  <= 1'b0;
      ready_q <= 1'b0;
      armed_q <= 1'b0;
      step_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      gate_q  <= gate_d;
      trip_q  <= trip_d;
      ready_q <= ready_d;
      armed_q <= armed_d;
      step_q  <= step_d;
      hold_q  <= hold_d;
    end
  end

  assign lvl_inc = (level_q == LVL_MAX) ? LVL_MAX : level_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    gate_d   = gate_q;
    trip_d   = trip_q;
    step_d   = '0;
    hold_d   = '0;
    trip_now = 1'b0;
    armed_d  = armed_q | ~i_rf_on_req;
    case (state_q)
      S_IDLE: begin
        level_d = '0;
        gate_d  = 1'b0;
        if (!perm_s && i_rf_on_req && armed_q) begin
          state_d = S_RAMP;
          gate_d  = 1'b1;
        end
      end
      S_RAMP, S_ON, S_REDUCED: begin
        if (perm_s) begin
          trip_now = 1'b1;
        end else if (!i_rf_on_req) begin
          state_d = S_IDLE;
          level_d = '0;
          gate_d  = 1'b0;
        end else if (state_q == S_ON) begin
          if (!red_s) begin
            level_d = LVL_RED;
            state_d = S_REDUCED;
          end
        end else if (state_q == S_REDUCED) begin
          if (red_s) state_d = S_RAMP;
        end else if (!red_s && level_q >= LVL_RED) begin
          level_d = LVL_RED;
          state_d = S_REDUCED;
        end else if (step_q == STEP_LAST) begin
          level_d = lvl_inc;
          if (lvl_inc == LVL_MAX)                 state_d = S_ON;
          else if (!red_s && lvl_inc == LVL_RED)  state_d = S_REDUCED;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      S_TRIP: begin
        level_d = '0;
        gate_d  = 1'b0;
        trip_d  = 1'b1;
        if (i_trip_ack && !perm_s) state_d = S_HOLDOFF;
      end
      S_HOLDOFF: begin
        if (perm_s) begin
          trip_now = 1'b1;
        end else if (hold_q == HOLD_LAST) begin
          state_d = S_IDLE;
          trip_d  = 1'b0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: trip_now = 1'b1;
    endcase
    // Trip entry drops the arm so a held request cannot restart RF after recovery.
    if (trip_now) begin
      state_d = S_TRIP;
      level_d = '0;
      gate_d  = 1'b0;
      trip_d  = 1'b1;
      armed_d = 1'b0;
    end
  end

  assign ready_d = (state_d == S_IDLE) & armed_d & ~perm_sync_q[0];

  assign o_drive_level = level_q;
  assign o_trip        = trip_q;
  assign o_ready       = ready_q;
  assign o_state       = state_q;
`ifdef RPSC_RF_FAST_TRIP_EN
  assign o_rf_gate = gate_q & ~i_not_rf_perm;
`else
  assign o_rf_gate = gate_q;
`endif

endmodule

// File: tb/tb_rpsc_rf_sequencer.sv
// tb/tb_rpsc_rf_sequencer.sv - self-checking bench for rpsc_rf_sequencer with a behavioural model
module tb_rpsc_rf_sequencer;

  localparam int RAMP_W = 4;
  localparam int STEP_DIV = 4;
  localparam int RED = 4;
  localparam int HOLD = 8;
  localparam int MAXL = 15;
`ifdef RPSC_RF_FAST_TRIP_EN
  localparam int FAST = 1;
`else
  localparam int FAST = 0;
`endif

  logic clk = 1'b0;
  logic rst_n, perm_n, red_n, req, ack;
  logic [RAMP_W-1:0] lvl;
  logic gate, trip, ready;
  logic [2:0] st;

  int n_cmp = 0;
  int n_fail = 0;

  // model: state codes 0 idle,1 ramp,2 on,3 reduced,4 trip,5 holdoff
  int m_state, m_level, m_ramp_elapsed, m_hold_elapsed;
  bit m_gate, m_trip, m_ready, m_armed;
  bit m_ps0, m_ps1, m_rs0, m_rs1;

  rpsc_rf_sequencer #(
    .RAMP_W(RAMP_W), .STEP_DIV(STEP_DIV), .RED_LEVEL(RED), .HOLDOFF_CYC(HOLD)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_not_rf_perm(perm_n), .i_not_rf_red(red_n),
    .i_rf_on_req(req), .i_trip_ack(ack),
    .o_drive_level(lvl), .o_rf_gate(gate), .o_trip(trip),
    .o_ready(ready), .o_state(st)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_level = 0; m_gate = 0; m_trip = 0; m_ready = 0; m_armed = 0;
    m_ramp_elapsed = 0; m_hold_elapsed = 0;
    m_ps0 = 1; m_ps1 = 1; m_rs0 = 1; m_rs1 = 1;
  endtask

  task automatic model_step();
    bit ps, rs, go_trip, arm_next;
    ps = m_ps1; rs = m_rs1; go_trip = 0;
    arm_next = m_armed | !req;
    case (m_state)
      0: if (!ps && req && m_armed) begin
           m_state = 1; m_gate = 1; m_ramp_elapsed = 0;
         end
      1, 2, 3: begin
        if (ps) go_trip = 1;
        else if (!req) begin m_state = 0; m_level = 0; m_gate = 0; end
        else if (m_state == 2) begin
          if (!rs) begin m_level = RED; m_state = 3; end
        end else if (m_state == 3) begin
          if (rs) begin m_state = 1; m_ramp_elapsed = 0; end
        end else if (!rs && m_level >= RED) begin
          m_level = RED; m_state = 3;
        end else begin
          m_ramp_elapsed++;
          if (m_ramp_elapsed % STEP_DIV == 0) begin
            m_level = (m_level < MAXL) ? m_level + 1 : MAXL;
            if (m_level == MAXL) m_state = 2;
            else if (!rs && m_level == RED) m_state = 3;
          end
        end
      end
      4: if (ack && !ps) begin m_state = 5; m_hold_elapsed = 0; end
      5: begin
        if (ps) go_trip = 1;
        else begin
          m_hold_elapsed++;
          if (m_hold_elapsed == HOLD) begin m_state = 0; m_trip = 0; end
        end
      end
      default: go_trip = 1;
    endcase
    if (go_trip) begin
      m_state = 4; m_level = 0; m_gate = 0; m_trip = 1; arm_next = 0;
    end
    m_armed = arm_next;
    m_ps1 = m_ps0; m_ps0 = perm_n;
    m_rs1 = m_rs0; m_rs0 = red_n;
    m_ready = (m_state == 0) && m_armed && !m_ps1;
  endtask

  task automatic cycle();
    int eg;
    @(posedge clk);
    if (!rst_n) model_reset(); else model_step();
    @(negedge clk);
    eg = FAST ? int'(m_gate & ~perm_n) : int'(m_gate);
    chk("model_state", int'(st), m_state);
    chk("model_level", int'(lvl), m_level);
    chk("model_gate", int'(gate), eg);
    chk("model_trip", int'(trip), int'(m_trip));
    chk("model_ready", int'(ready), int'(m_ready));
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_state", int'(st), 0);
    chk("rst_level", int'(lvl), 0);
    chk("rst_gate", int'(gate), 0);
    chk("rst_trip", int'(trip), 0);
    chk("rst_ready", int'(ready), 0);
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1; perm_n = 1'b0; red_n = 1'b1; req = 1'b0; ack = 1'b0;
    model_reset();
    #2;
    async_reset();

    // start and full ramp
    cycles(3);
    chk("ready_before_start", int'(ready), 1);
    req = 1'b1;
    cycle();
    chk("ramp_entry_state", int'(st), 1);
    chk("ramp_entry_gate", int'(gate), 1);
    cycles(4);
    chk("level_after_4", int'(lvl), 1);
    cycles(55);
    chk("level_after_59", int'(lvl), 14);
    chk("state_after_59", int'(st), 1);
    cycle();
    chk("level_after_60", int'(lvl), 15);
    chk("state_on", int'(st), 2);

    // reduce and release
    red_n = 1'b0;
    cycles(2);
    chk("red_edge2_level", int'(lvl), 15);
    cycle();
    chk("red_edge3_level", int'(lvl), 4);
    chk("red_edge3_state", int'(st), 3);
    red_n = 1'b1;
    cycles(3);
    chk("release_state", int'(st), 1);
    cycles(43);
    chk("rel_level_43", int'(lvl), 14);
    cycle();
    chk("rel_level_44", int'(lvl), 15);
    chk("rel_state_44", int'(st), 2);

    // trip and recovery
    perm_n = 1'b1;
    #1;
    if (FAST != 0) chk("fast_gate_now", int'(gate), 0);
    cycles(2);
    chk("trip_edge2_gate", int'(gate), FAST ? 0 : 1);
    cycle();
    chk("trip_state", int'(st), 4);
    chk("trip_level", int'(lvl), 0);
    chk("trip_gate", int'(gate), 0);
    chk("trip_flag", int'(trip), 1);
    ack = 1'b1; cycle(); ack = 1'b0;
    cycle();
    chk("ack_ignored", int'(st), 4);
    perm_n = 1'b0;
    cycles(3);
    ack = 1'b1; cycle(); ack = 1'b0;
    chk("holdoff_entry", int'(st), 5);
    cycles(7);
    chk("holdoff_7", int'(st), 5);
    cycle();
    chk("holdoff_done_state", int'(st), 0);
    chk("holdoff_done_trip", int'(trip), 0);
    chk("ready_held_req", int'(ready), 0);
    req = 1'b0;
    cycle();
    chk("ready_after_drop", int'(ready), 1);

    // request drop mid-ramp
    req = 1'b1;
    cycle();
    cycles(28);
    chk("mid_ramp_level", int'(lvl), 7);
    req = 1'b0;
    cycle();
    chk("drop_state", int'(st), 0);
    chk("drop_level", int'(lvl), 0);
    chk("drop_gate", int'(gate), 0);

    // asynchronous reset mid-ON, no restart until request toggles
    req = 1'b1;
    cycles(61);
    chk("on_before_reset", int'(st), 2);
    async_reset();
    cycles(10);
    chk("no_restart", int'(st), 0);
    req = 1'b0; cycle();
    req = 1'b1; cycle();
    chk("restart_after_toggle", int'(st), 1);

    // randomized phase
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 1999) == 0) async_reset();
      if ($urandom_range(0, 79) == 0) perm_n = ~perm_n;
      if ($urandom_range(0, 19) == 0) red_n = ~red_n;
      if ($urandom_range(0, 59) == 0) req = ~req;
      ack = ($urandom_range(0, 9) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
